ins_fetch_decode: RTL and testbench
===================================

Name: ins_fetch_decode

Overview:
- Two-wide fetch/decode front end that drives the instruction-insert side of the pre-calculation and queue block.
- Fetches instruction pairs from an instruction memory with fixed 1-cycle latency and splits each 21-bit word into op/des/s1/s2/ime.
- Presents up to two instructions per cycle on ins_new_1/2, honouring entry_full and branch_full.
- Redirects its PC on flush_en and stops fetching on HALT.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request for words imem_addr and imem_addr+1.
- imem_addr  out  ADDR_W  fetch address; always even.
- imem_rdata_0  in  21  word at imem_addr; valid when imem_rvld=1.
- imem_rdata_1  in  21  word at imem_addr+1.
- imem_rvld  in  1  response valid; asserted exactly 1 cycle after imem_req.
- entry_full  in  1  queue cannot accept new instructions.
- branch_full  in  1  queue has no free branch tag.
- flush_en  in  1  mispredict/redirect.
- flush_pc  in  ADDR_W  redirect target (bit0 ignored, forced 0).
- ins_new_1_vld, ins_new_2_vld  out  1 each  slot valid; the queue accepts whenever asserted.
- ins_1_op/des/s1/s2  out  4 each  slot-1 fields.
- ins_1_ime  out  5  slot-1 immediate.
- ins_2_op/des/s1/s2  out  4 each  slot-2 fields.
- ins_2_ime  out  5  slot-2 immediate.

Behaviour:
- Word layout: [20:17] op, [16:13] des, [12:9] s1, [8:5] s2, [4:0] ime.
- Opcodes: OP_BR=4'hC is a branch; OP_HALT=4'hF is a halt.
- Reset (rst=0, async):
  - pc=RESET_PC, state=FETCH.
  - Hold buffer empty, all outputs 0; imem_addr=RESET_PC.
- Hold buffer: two slots (h0, h1), each with a valid bit. Field outputs are registered copies of h0/h1.
- Valid outputs (combinational):
  - ins_new_1_vld = h0.v & ~entry_full & ~(h0 is BR & branch_full).
  - ins_new_2_vld = ins_new_1_vld & h1.v & ~(h1 is BR & (branch_full | h0 is BR)).
  - Consequence: at most one branch is issued per cycle.
- Partial issue: if only slot 1 issues while h1 is valid, h1 moves to h0 at the next edge and h1 becomes invalid.
- FSM states FETCH, HALT:
  - FETCH: imem_req=1 when no request is outstanding and the hold buffer is empty or fully drains this cycle. On the request, pc+=2 at the edge.
  - On imem_rvld the decoded pair loads the hold buffer.
  - If a word has op==OP_HALT: that word and every later word in the pair are discarded, earlier words are kept, and state goes to HALT.
  - HALT: imem_req=0; any remaining hold contents still issue. Leave only on flush_en.
- Flush (highest priority, same cycle as any other event):
  - Both vld outputs forced 0 that cycle; hold buffer cleared.
  - Any in-flight response is dropped: the next imem_rvld is ignored.
  - pc={flush_pc[ADDR_W-1:1],0}, state=FETCH. Fetch resumes the next cycle.
- pc wraps modulo 2^ADDR_W.
- Stall: hold contents and field outputs stay stable while vld is 0.
- Latency:
  - Request in cycle t, data presented on ins_* in cycle t+2.
  - Without the skid option, throughput is at most one pair per 2 cycles.

Optional Feature:
- Macro FETCH_SKID_EN.
- Defined:
  - Adds a 2-word skid register. A request may be issued while one is outstanding provided the skid register will be free.
  - A response arriving while the hold buffer cannot take it goes to skid; skid moves to hold when hold drains.
  - Steady-state throughput is one pair per cycle. Flush also clears skid.
- Undefined: at most one outstanding request, as described above.

Decomposition:
- Package pre_calc_pkg:
  - Field width constants; OP_BR, OP_HALT.
  - ins_t struct {op, des, s1, s2, ime}.
  - fetch_state_e enum {FETCH, HALT}.
- Sub-module ins_field_decoder: combinational. Input one 21-bit word; outputs ins_t plus is_br and is_halt. Instantiated twice.

Test Plan:
- Reset, memory returns adds at 0,1 then 2,3:
  - imem_addr 0 then 2.
  - Both vld=1 two cycles after the first request, with fields matching the words.
- entry_full=1 for 3 cycles while a pair is held: vld=0 and fields stable; on release both issue in the same cycle, with no loss or duplication.
- Pair {BR, BR} with branch_full=0:
  - Slot 1 issues alone.
  - Next cycle the second BR appears in slot 1 with ins_new_2_vld=0.
- Pair {ADD, HALT} at addr 6: ADD issues, HALT is never issued, and imem_req stays 0 thereafter. Then flush_en with flush_pc=0x11: imem_addr=0x10 next cycle.
- flush_en in the cycle imem_rvld arrives: response discarded, vld=0, fetch restarts at the flush target.
- FETCH_SKID_EN build, no stalls: imem_req high every cycle, one pair issued per cycle. rst asserted mid-stream: outputs go to 0 immediately.

Source files
------------

// File: rtl/pre_calc_pkg.sv
// Shared types for the fetch/decode front end feeding the pre-calc queue.
// Word layout, opcode constants, decoded-instruction and hold-slot bundles.
package pre_calc_pkg;

    localparam int INS_W = 21;
    localparam int OP_W  = 4;
    localparam int REG_W = 4;
    localparam int IME_W = 5;

    localparam logic [OP_W-1:0] OP_BR   = 4'hC;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] des;
        logic [REG_W-1:0] s1;
        logic [REG_W-1:0] s2;
        logic [IME_W-1:0] ime;
    } ins_t;

    typedef struct packed {
        ins_t ins;
        logic br;
        logic v;
    } slot_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ins_field_decoder.sv
// Splits one 21-bit instruction word into fields and flags branch/halt.
// Purely combinational.
module ins_field_decoder
    import pre_calc_pkg::*;
(
    input  logic [INS_W-1:0] word_i,
    output ins_t             ins_o,
    output logic             is_br_o,
    output logic             is_halt_o
);

    always_comb begin
        ins_o.op  = word_i[20:17];
        ins_o.des = word_i[16:13];
        ins_o.s1  = word_i[12:9];
        ins_o.s2  = word_i[8:5];
        ins_o.ime = word_i[4:0];
    end

    assign is_br_o   = (word_i[20:17] == OP_BR);
    assign is_halt_o = (word_i[20:17] == OP_HALT);

endmodule

// File: rtl/ins_fetch_decode.sv
// Two-wide fetch/decode front end with a two-slot hold buffer.
// Define FETCH_SKID_EN for a 2-word skid register and 1 pair/cycle fetch.
module ins_fetch_decode
    import pre_calc_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_rdata_0,
    input  logic [INS_W-1:0]  imem_rdata_1,
    input  logic              imem_rvld,
    input  logic              entry_full,
    input  logic              branch_full,
    input  logic              flush_en,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              ins_new_1_vld,
    output logic              ins_new_2_vld,
    output logic [3:0]        ins_1_op,
    output logic [3:0]        ins_1_des,
    output logic [3:0]        ins_1_s1,
    output logic [3:0]        ins_1_s2,
    output logic [4:0]        ins_1_ime,
    output logic [3:0]        ins_2_op,
    output logic [3:0]        ins_2_des,
    output logic [3:0]        ins_2_s1,
    output logic [3:0]        ins_2_s2,
    output logic [4:0]        ins_2_ime
);

    ins_t              dec0, dec1;
    logic              br0, br1, halt0, halt1;
    slot_t             r0, r1;
    slot_t             h0_q, h0_d, h1_q, h1_d;
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              run_q;
    logic              vld1, vld2, hold_free;
    logic              resp, halt_seen, req;

    ins_field_decoder u_dec0 (
        .word_i    (imem_rdata_0),
        .ins_o     (dec0),
        .is_br_o   (br0),
        .is_halt_o (halt0)
    );

    ins_field_decoder u_dec1 (
        .word_i    (imem_rdata_1),
        .ins_o     (dec1),
        .is_br_o   (br1),
        .is_halt_o (halt1)
    );

    // A halt word kills itself and everything after it in the pair
    assign r0 = '{ins: dec0, br: br0, v: ~halt0};
    assign r1 = '{ins: dec1, br: br1, v: ~halt0 & ~halt1};

    assign vld1 = h0_q.v & ~entry_full
                & ~(h0_q.br & branch_full) & ~flush_en;
    assign vld2 = vld1 & h1_q.v
                & ~(h1_q.br & (branch_full | h0_q.br));

    assign hold_free = ~h0_q.v | (vld1 & (~h1_q.v | vld2));
    assign resp      = imem_rvld & ~flush_en & (state_q == FETCH);
    assign halt_seen = resp & (halt0 | halt1);

`ifdef FETCH_SKID_EN
    slot_t k0_q, k0_d, k1_q, k1_d;

    assign req = run_q & (state_q == FETCH) & ~flush_en
               & ~halt_seen & ~k0_d.v;
`else
    logic pend_q;

    assign req = run_q & (state_q == FETCH) & ~flush_en
               & ~halt_seen & ~pend_q & hold_free;
`endif

    always_comb begin
        h0_d = h0_q;
        h1_d = h1_q;
`ifdef FETCH_SKID_EN
        k0_d = k0_q;
        k1_d = k1_q;
`endif
        if (vld1 && h1_q.v && !vld2) begin
            h0_d   = h1_q;
            h1_d.v = 1'b0;
        end else if (vld1) begin
            h0_d.v = 1'b0;
            h1_d.v = 1'b0;
        end
`ifdef FETCH_SKID_EN
        if (hold_free && k0_q.v) begin
            h0_d   = k0_q;
            h1_d   = k1_q;
            k0_d.v = 1'b0;
            k1_d.v = 1'b0;
            if (resp) begin
                k0_d = r0;
                k1_d = r1;
            end
        end else if (resp) begin
            if (hold_free) begin
                h0_d = r0;
                h1_d = r1;
            end else begin
                k0_d = r0;
                k1_d = r1;
            end
        end
`else
        if (resp) begin
            h0_d = r0;
            h1_d = r1;
        end
`endif
        if (flush_en) begin
            h0_d.v = 1'b0;
            h1_d.v = 1'b0;
`ifdef FETCH_SKID_EN
            k0_d.v = 1'b0;
            k1_d.v = 1'b0;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (req) begin
            pc_d = pc_q + ADDR_W'(2);
        end
        if (halt_seen) begin
            state_d = HALT;
        end
        if (flush_en) begin
            state_d = FETCH;
            pc_d    = flush_pc & ~ADDR_W'(1);
        end
    end

    // run_q keeps imem_req low while reset is held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            run_q   <= 1'b0;
            h0_q    <= '0;
            h1_q    <= '0;
`ifdef FETCH_SKID_EN
            k0_q    <= '0;
            k1_q    <= '0;
`else
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= 1'b1;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
`ifdef FETCH_SKID_EN
            k0_q    <= k0_d;
            k1_q    <= k1_d;
`else
            pend_q  <= req;
`endif
        end
    end

    assign imem_req  = req;
    assign imem_addr = pc_q;

    assign ins_new_1_vld = vld1;
    assign ins_new_2_vld = vld2;

    assign ins_1_op  = h0_q.ins.op;
    assign ins_1_des = h0_q.ins.des;
    assign ins_1_s1  = h0_q.ins.s1;
    assign ins_1_s2  = h0_q.ins.s2;
    assign ins_1_ime = h0_q.ins.ime;
    assign ins_2_op  = h1_q.ins.op;
    assign ins_2_des = h1_q.ins.des;
    assign ins_2_s1  = h1_q.ins.s1;
    assign ins_2_s2  = h1_q.ins.s2;
    assign ins_2_ime = h1_q.ins.ime;

endmodule

// File: tb/tb_ins_fetch_decode.sv
// Bench for ins_fetch_decode: memory responder plus issue scoreboard.
// Works in both the default and FETCH_SKID_EN builds.
module tb_ins_fetch_decode;

`ifdef FETCH_SKID_EN
    localparam int PAIRS = 8;
`else
    localparam int PAIRS = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [20:0] imem_rdata_0, imem_rdata_1;
    logic        imem_rvld;
    logic        entry_full, branch_full, flush_en;
    logic [7:0]  flush_pc;
    logic        vld1, vld2;
    logic [3:0]  op1, des1, s11, s21, op2, des2, s12, s22;
    logic [4:0]  ime1, ime2;
    logic [20:0] got1, got2;

    logic [20:0] mem [256];
    logic [20:0] exp_q [$];
    bit          halted_m;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign got1 = {op1, des1, s11, s21, ime1};
    assign got2 = {op2, des2, s12, s22, ime2};

    ins_fetch_decode #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata_0 (imem_rdata_0),
        .imem_rdata_1 (imem_rdata_1),
        .imem_rvld    (imem_rvld),
        .entry_full   (entry_full),
        .branch_full  (branch_full),
        .flush_en     (flush_en),
        .flush_pc     (flush_pc),
        .ins_new_1_vld(vld1),
        .ins_new_2_vld(vld2),
        .ins_1_op     (op1),
        .ins_1_des    (des1),
        .ins_1_s1     (s11),
        .ins_1_s2     (s21),
        .ins_1_ime    (ime1),
        .ins_2_op     (op2),
        .ins_2_des    (des2),
        .ins_2_s1     (s12),
        .ins_2_s2     (s22),
        .ins_2_ime    (ime2)
    );

    function automatic logic [20:0] mkw(input logic [3:0] op,
                                        input logic [3:0] d,
                                        input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [4:0] im);
        return {op, d, a, b, im};
    endfunction

    task automatic push_word(input logic [20:0] w);
        if (!halted_m) begin
            if (w[20:17] == 4'hF) halted_m = 1'b1;
            else exp_q.push_back(w);
        end
    endtask

    // One clock: scoreboard the issue slots, then answer last request
    task automatic tick();
        logic [20:0] e;
        logic        rq;
        logic [7:0]  ad;
        if (vld1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_slot1: issued %h, required none", got1);
            end else begin
                e = exp_q.pop_front();
                if (got1 !== e) begin
                    errors++;
                    $display("FAIL sb_slot1: got %h, required %h", got1, e);
                end
            end
        end
        if (vld2) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_slot2: issued %h, required none", got2);
            end else begin
                e = exp_q.pop_front();
                if (got2 !== e) begin
                    errors++;
                    $display("FAIL sb_slot2: got %h, required %h", got2, e);
                end
            end
        end
        rq = imem_req;
        ad = imem_addr;
        @(posedge clk);
        #1;
        imem_rvld    = rq;
        imem_rdata_0 = mem[ad];
        imem_rdata_1 = mem[ad + 8'd1];
        if (rq) begin
            push_word(mem[ad]);
            push_word(mem[ad + 8'd1]);
        end
        #1;
    endtask

    task automatic restart(input logic [7:0] a);
        flush_en = 1'b1;
        flush_pc = a;
        exp_q.delete();
        halted_m = 1'b0;
        tick();
        flush_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({vld1, vld2, imem_req} !== 3'b000) begin
            errors++;
            $display("FAIL rst_ctl: got %b, required 000",
                     {vld1, vld2, imem_req});
        end
        checks++;
        if (imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL rst_addr: got %h, required 00", imem_addr);
        end
        checks++;
        if ({got1, got2} !== 42'd0) begin
            errors++;
            $display("FAIL rst_fields: got %h %h, required 0", got1, got2);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tick();
    endtask

    task automatic test_fetch_basic();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL basic_req0: got %b/%h, required 1/00",
                     imem_req, imem_addr);
        end
        tick();
        checks++;
        if (imem_addr !== 8'h02) begin
            errors++;
            $display("FAIL basic_addr2: got %h, required 02", imem_addr);
        end
`ifndef FETCH_SKID_EN
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_out: req %b, required 0", imem_req);
        end
`endif
        tick();
        checks++;
        if ({vld1, vld2} !== 2'b11) begin
            errors++;
            $display("FAIL basic_vld: got %b, required 11", {vld1, vld2});
        end
        checks++;
        if ({got1, got2} !== {mem[0], mem[1]}) begin
            errors++;
            $display("FAIL basic_fields: got %h %h, required %h %h",
                     got1, got2, mem[0], mem[1]);
        end
        tick();
    endtask

    task automatic test_entry_full();
        restart(8'h30);
        entry_full = 1'b1;
        #1;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({vld1, vld2} !== 2'b00
                || {got1, got2} !== {mem[8'h30], mem[8'h31]}) begin
                errors++;
                $display("FAIL stall_hold: vld %b fields %h %h, req 00 %h %h",
                         {vld1, vld2}, got1, got2, mem[8'h30], mem[8'h31]);
            end
            tick();
        end
        entry_full = 1'b0;
        #1;
        checks++;
        if ({vld1, vld2} !== 2'b11) begin
            errors++;
            $display("FAIL stall_release: got %b, required 11", {vld1, vld2});
        end
        tick();
    endtask

    task automatic test_branch_pair();
        restart(8'h50);
        entry_full = 1'b1;
        #1;
        repeat (4) tick();
        entry_full  = 1'b0;
        branch_full = 1'b1;
        #1;
        checks++;
        if (vld1 !== 1'b0) begin
            errors++;
            $display("FAIL br_full_block: vld1 %b, required 0", vld1);
        end
        branch_full = 1'b0;
        #1;
        checks++;
        if ({vld1, vld2, op1} !== {2'b10, 4'hC}) begin
            errors++;
            $display("FAIL br_first: vld %b op %h, required 10 c",
                     {vld1, vld2}, op1);
        end
        tick();
        checks++;
        if ({vld1, vld2} !== 2'b10 || got1 !== mem[8'h51]) begin
            errors++;
            $display("FAIL br_second: vld %b ins %h, required 10 %h",
                     {vld1, vld2}, got1, mem[8'h51]);
        end
        tick();
    endtask

    task automatic test_halt();
        restart(8'h06);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h06}) begin
            errors++;
            $display("FAIL halt_req: got %b/%h, required 1/06",
                     imem_req, imem_addr);
        end
        tick();
        tick();
        checks++;
        if ({vld1, vld2, imem_req} !== 3'b100 || got1 !== mem[6]) begin
            errors++;
            $display("FAIL halt_add: ctl %b ins %h, required 100 %h",
                     {vld1, vld2, imem_req}, got1, mem[6]);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({imem_req, vld1} !== 2'b00) begin
                errors++;
                $display("FAIL halt_quiet: req/vld1 %b, required 00",
                         {imem_req, vld1});
            end
            tick();
        end
    endtask

    task automatic test_flush_redirect();
        flush_en = 1'b1;
        flush_pc = 8'h11;
        exp_q.delete();
        halted_m = 1'b0;
        tick();
        flush_en = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h10}) begin
            errors++;
            $display("FAIL flush_target: got %b/%h, required 1/10",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_flush_on_rvld();
        tick();
        flush_en = 1'b1;
        flush_pc = 8'h24;
        exp_q.delete();
        halted_m = 1'b0;
        #1;
        checks++;
        if ({vld1, vld2} !== 2'b00) begin
            errors++;
            $display("FAIL frv_vld: got %b, required 00", {vld1, vld2});
        end
        tick();
        flush_en = 1'b0;
        #1;
        checks++;
        if ({vld1, vld2} !== 2'b00) begin
            errors++;
            $display("FAIL frv_drop: got %b, required 00", {vld1, vld2});
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h24}) begin
            errors++;
            $display("FAIL frv_target: got %b/%h, required 1/24",
                     imem_req, imem_addr);
        end
        tick();
        tick();
        checks++;
        if ({vld1, vld2} !== 2'b11 || got1 !== mem[8'h24]) begin
            errors++;
            $display("FAIL frv_resume: vld %b ins %h, required 11 %h",
                     {vld1, vld2}, got1, mem[8'h24]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int nr;
        int np;
        restart(8'h40);
        tick();
        tick();
        nr = 0;
        np = 0;
        for (int i = 0; i < 8; i++) begin
            nr += int'(imem_req);
            np += int'(vld2);
            tick();
        end
        checks++;
        if (nr !== PAIRS) begin
            errors++;
            $display("FAIL b2b_req: got %0d, required %0d", nr, PAIRS);
        end
        checks++;
        if (np !== PAIRS) begin
            errors++;
            $display("FAIL b2b_pairs: got %0d, required %0d", np, PAIRS);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({vld1, vld2, imem_req, imem_addr} !== 11'd0
            || {got1, got2} !== 42'd0) begin
            errors++;
            $display("FAIL midrst: ctl %b addr %h ins %h %h, required 0",
                     {vld1, vld2, imem_req}, imem_addr, got1, got2);
        end
        exp_q.delete();
        imem_rvld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] a;
        rst          = 1'b0;
        imem_rvld    = 1'b0;
        imem_rdata_0 = '0;
        imem_rdata_1 = '0;
        entry_full   = 1'b0;
        branch_full  = 1'b0;
        flush_en     = 1'b0;
        flush_pc     = '0;
        halted_m     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            mem[i] = mkw(a[0] ? 4'h2 : 4'h1, a[7:4], a[3:0],
                         ~a[3:0], a[4:0]);
        end
        mem[8'h07] = mkw(4'hF, 4'h0, 4'h0, 4'h0, 5'h00);
        mem[8'h50] = mkw(4'hC, 4'h1, 4'h2, 4'h3, 5'h04);
        mem[8'h51] = mkw(4'hC, 4'h5, 4'h6, 4'h7, 5'h08);

        test_reset();
        test_fetch_basic();
        test_entry_full();
        test_branch_pair();
        test_halt();
        test_flush_redirect();
        test_flush_on_rvld();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
